// File: rtl/mac_arb_pkg.sv
// mac_arb_pkg: shared types and default sizes for the multiply-add arbiter
package mac_arb_pkg;
  localparam int W_DEF = 8;
  localparam int LAT_DEF = 3;
  localparam int DEPTH_DEF = 2;
  typedef logic id_t;
  typedef struct packed {
    logic valid;
    id_t  id;
  } tag_t;
  typedef enum logic {PRI0, PRI1} pri_e;
endpackage

// File: rtl/mac_arb_rsp_fifo.sv
// mac_arb_rsp_fifo: DEPTH-entry response FIFO; the caller guarantees no write when full
module mac_arb_rsp_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [CW-1:0] cnt;
  logic pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid = cnt != '0;
  assign data = mem[rp];
  assign pop = valid && ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rp <= '0;
      wp <= '0;
      cnt <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= wdata;
        wp <= inc(wp);
      end
      if (pop) rp <= inc(rp);
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  end
endmodule

// File: rtl/mac_arbiter.sv
// mac_arbiter: round-robin, credit-gated sharing of a fixed-latency multiply-add pipeline
// Optional per-requester statistics counters under MAC_ARB_STATS_EN.
module mac_arbiter
  import mac_arb_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int LAT = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req0_c,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [W-1:0] req1_c,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  output logic [W-1:0] dp_c,
  input  logic [W-1:0] dp_result,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data
`ifdef MAC_ARB_STATS_EN
  ,
  output logic [15:0]  stat_issue0,
  output logic [15:0]  stat_issue1,
  output logic [15:0]  stat_block
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  pri_e state, nxt;
  logic [CW-1:0] cred0, cred1;
  logic elig0, elig1, g0, g1, pop0, pop1;
  tag_t [LAT:0] tags;
  assign elig0 = req0_valid && cred0 < CW'(DEPTH);
  assign elig1 = req1_valid && cred1 < CW'(DEPTH);
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign pop0 = rsp0_valid && rsp0_ready;
  assign pop1 = rsp1_valid && rsp1_ready;
  always_comb begin
    g0 = state == PRI0 ? elig0 : elig0 && !elig1;
    g1 = state == PRI1 ? elig1 : elig1 && !elig0;
    nxt = g0 ? PRI1 : g1 ? PRI0 : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRI0;
    else state <= nxt;
  end
  // tags[LAT] lines up with the cycle dp_result holds that beat's result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a <= '0;
      dp_b <= '0;
      dp_c <= '0;
      tags <= '0;
      cred0 <= '0;
      cred1 <= '0;
    end else begin
      if (g0 || g1) begin
        dp_a <= g1 ? req1_a : req0_a;
        dp_b <= g1 ? req1_b : req0_b;
        dp_c <= g1 ? req1_c : req0_c;
      end
      tags <= {tags[LAT-1:0], tag_t'{valid: g0 || g1, id: g1}};
      cred0 <= cred0 + CW'(g0) - CW'(pop0);
      cred1 <= cred1 + CW'(g1) - CW'(pop1);
    end
  end
  mac_arb_rsp_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .wr(tags[LAT].valid && !tags[LAT].id), .wdata(dp_result),
    .valid(rsp0_valid), .ready(rsp0_ready), .data(rsp0_data)
  );
  mac_arb_rsp_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .wr(tags[LAT].valid && tags[LAT].id), .wdata(dp_result),
    .valid(rsp1_valid), .ready(rsp1_ready), .data(rsp1_data)
  );
`ifdef MAC_ARB_STATS_EN
  logic blk;
  assign blk = (req0_valid && cred0 == CW'(DEPTH)) || (req1_valid && cred1 == CW'(DEPTH));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue0 <= '0;
      stat_issue1 <= '0;
      stat_block <= '0;
    end else begin
      stat_issue0 <= stat_issue0 + 16'(g0 && stat_issue0 != 16'hFFFF);
      stat_issue1 <= stat_issue1 + 16'(g1 && stat_issue1 != 16'hFFFF);
      stat_block <= stat_block + 16'(blk && stat_block != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_mac_arbiter.sv
// tb_mac_arbiter: directed plus randomized checks of mac_arbiter against a queue-based model
module tb_mac_arbiter;
  localparam int W = 8;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req0_c = 0, req1_a = 0, req1_b = 0, req1_c = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [W-1:0] dp_a, dp_b, dp_c, rsp0_data, rsp1_data;
  logic [W-1:0] dp_result = 0, p1 = 0, p2 = 0;
  int passed = 0, total = 0, cyc = 0, last = 1;
  int outst[2];
  int q_val[2][$];
  int q_time[2][$];
  logic [W-1:0] ea = 0, eb = 0, ec = 0;

  mac_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_result(dp_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data)
  );

  always #5 clk = ~clk;

  // stand-in for the 3-stage multiply-add pipeline
  always @(posedge clk) begin
    p1 <= dp_a * dp_b + dp_c;
    p2 <= p1;
    dp_result <= p2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
  endtask

  task automatic step(input bit v0, input logic [W-1:0] a0, b0, c0,
                      input bit v1, input logic [W-1:0] a1, b1, c1,
                      input bit r0, input bit r1);
    bit e0, e1, g0, g1, vis0, vis1;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_c = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_c = c1;
    rsp0_ready = r0; rsp1_ready = r1;
    #1;
    e0 = v0 && outst[0] < DEPTH;
    e1 = v1 && outst[1] < DEPTH;
    g0 = e0 && (!e1 || last == 1);
    g1 = e1 && !g0;
    vis0 = q_time[0].size() > 0 && q_time[0][0] <= cyc;
    vis1 = q_time[1].size() > 0 && q_time[1][0] <= cyc;
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    check("rsp0_valid", 32'(rsp0_valid), 32'(vis0));
    check("rsp1_valid", 32'(rsp1_valid), 32'(vis1));
    if (vis0) check("rsp0_data", 32'(rsp0_data), 32'(q_val[0][0]));
    if (vis1) check("rsp1_data", 32'(rsp1_data), 32'(q_val[1][0]));
    check("dp_abc", {8'd0, dp_a, dp_b, dp_c}, {8'd0, ea, eb, ec});
    @(posedge clk);
    cyc++;
    if (vis0 && r0) begin void'(q_val[0].pop_front()); void'(q_time[0].pop_front()); outst[0]--; end
    if (vis1 && r1) begin void'(q_val[1].pop_front()); void'(q_time[1].pop_front()); outst[1]--; end
    if (g0) begin
      q_val[0].push_back((int'(a0) * int'(b0) + int'(c0)) % 256); q_time[0].push_back(cyc + 4);
      outst[0]++; last = 0; ea = a0; eb = b0; ec = c0;
    end
    if (g1) begin
      q_val[1].push_back((int'(a1) * int'(b1) + int'(c1)) % 256); q_time[1].push_back(cyc + 4);
      outst[1]++; last = 1; ea = a1; eb = b1; ec = c1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("rst_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 0);
    check("rst_dp", {8'd0, dp_a, dp_b, dp_c}, 0);
    check("rst_rsp_data", {16'd0, rsp0_data, rsp1_data}, 0);
    rst_n = 1;
    for (int n = 0; n < 2; n++) begin q_val[n].delete(); q_time[n].delete(); outst[n] = 0; end
    last = 1; ea = 0; eb = 0; ec = 0;
  endtask

  initial begin
    outst[0] = 0; outst[1] = 0;
    repeat (2) @(posedge clk);
    cyc = 2;
    do_reset();
    step(1, 3, 4, 5, 0, 0, 0, 0, 1, 1);
    repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (4) step(1, 2, 3, 1, 1, 5, 5, 0, 1, 1);
    step(0, 0, 0, 0, 1, 20, 20, 1, 1, 1);
    repeat (6) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (8) step(1, 7, 9, 3, 1, 11, 2, 4, 0, 1);
    repeat (8) step(1, 6, 6, 6, 1, 1, 2, 3, 1, 1);
    repeat (3) step(1, 8, 8, 8, 0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (8) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    repeat (4) step(1, 9, 9, 9, 1, 4, 4, 4, 1, 1);
    repeat (8) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int blk = 0; blk < 15; blk++) begin
      int bv, br;
      bv = $urandom_range(1, 4);
      br = $urandom_range(0, 4);
      for (int k = 0; k < 200; k++)
        step($urandom_range(0, 3) < bv, W'($urandom), W'($urandom), W'($urandom),
             $urandom_range(0, 3) < bv, W'($urandom), W'($urandom), W'($urandom),
             $urandom_range(0, 3) < br, $urandom_range(0, 3) < br);
      if (blk == 7) do_reset();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
